// File: rtl/wb_button_led_pkg.sv
// Shared constants for the Wishbone button/LED peripheral: register word
// offsets, CTRL bit positions and the value returned for unmapped offsets.
package wb_button_led_pkg;

  localparam logic [2:0] OFF_LED_OUT     = 3'd0;
  localparam logic [2:0] OFF_BTN_IN      = 3'd1;
  localparam logic [2:0] OFF_EDGE_STATUS = 3'd2;
  localparam logic [2:0] OFF_IRQ_MASK    = 3'd3;
  localparam logic [2:0] OFF_CTRL        = 3'd4;

  localparam int CTRL_MIRROR_BIT = 0;
  localparam int CTRL_TOGGLE_BIT = 1;

  localparam logic [31:0] RESERVED_READ = 32'h0000_0000;

  // Expand the four byte enables into a 32-bit per-bit write mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One button channel: two-flop synchroniser, stability counter and a
// single-cycle pulse on an accepted 0->1 change of the debounced level.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic pin,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] count;
  logic          accept;

  assign accept = (sync_2 != level) && (count == CNT_LAST);
  assign rise   = accept && sync_2;

  // Synchronise the pin, then only adopt a new level once it has differed from the debounced level for the full window.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      count  <= '0;
      level  <= 1'b0;
    end else begin
      sync_1 <= pin;
      sync_2 <= sync_1;
      if (sync_2 == level) begin
        count <= '0;
      end else if (accept) begin
        level <= sync_2;
        count <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/wb_button_led_ctrl.sv
// Wishbone slave that debounces buttons, drives LEDs (direct, mirror or
// toggle mode) and latches sticky rising-edge events behind a maskable irq.
module wb_button_led_ctrl
  import wb_button_led_pkg::*;
#(
  parameter int          NUM_BUTTONS     = 3,
  parameter int          NUM_LEDS        = 8,
  parameter int          DEBOUNCE_CYCLES = 1000,
  parameter logic [31:0] BASE_ADDR       = 32'h3000_0000
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n,
  input  logic                wbs_stb_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_adr_i,
  input  logic [31:0]         wbs_dat_i,
  output logic                wbs_ack_o,
  output logic [31:0]         wbs_dat_o,
  input  logic [NUM_BUTTONS-1:0] buttons,
  output logic [NUM_LEDS-1:0] leds,
  output logic [NUM_LEDS-1:0] leds_oeb,
  output logic                irq
);

  if (NUM_LEDS < NUM_BUTTONS || DEBOUNCE_CYCLES < 2) begin : g_bad_params
    $error("wb_button_led_ctrl: NUM_LEDS must be >= NUM_BUTTONS and DEBOUNCE_CYCLES >= 2");
  end

  logic [NUM_BUTTONS-1:0] btn_level;
  logic [NUM_BUTTONS-1:0] btn_rise;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clock  (wb_clk_i),
      .reset_n(wb_rst_n),
      .pin    (buttons[i]),
      .level  (btn_level[i]),
      .rise   (btn_rise[i])
    );
  end

  logic [NUM_LEDS-1:0]    led_out;
  logic [NUM_BUTTONS-1:0] edge_status;
  logic [NUM_BUTTONS-1:0] irq_mask;
  logic [1:0]             ctrl;
  logic                   served;

  logic        sel_hit;
  logic        take;
  logic        wr;
  logic [2:0]  word_off;
  logic [31:0] wmask;
  logic [31:0] wbits;
  logic [31:0] rdata;

  logic [NUM_LEDS-1:0]    led_out_next;
  logic [NUM_BUTTONS-1:0] edge_next;
  logic [NUM_BUTTONS-1:0] irq_mask_next;
  logic [1:0]             ctrl_next;
  logic [31:0]            led_merge;
  logic [31:0]            mask_merge;
  logic [31:0]            ctrl_merge;
  logic [31:0]            edge_clear;

  // A select that has already been acked must drop before it is served again.
  assign sel_hit  = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
  assign take     = sel_hit & ~served;
  assign wr       = take & wbs_we_i;
  assign word_off = wbs_adr_i[4:2];
  assign wmask    = lane_mask(wbs_sel_i);
  assign wbits    = wbs_dat_i & wmask;
  assign leds_oeb = '0;

  logic unused_bits;
  assign unused_bits = ^{wbs_adr_i[1:0], led_merge, mask_merge, ctrl_merge, edge_clear};

  // Read mux; reserved offsets and bits above each register's width read as zero.
  always_comb begin
    rdata = RESERVED_READ;
    case (word_off)
      OFF_LED_OUT:     rdata = 32'(led_out);
      OFF_BTN_IN:      rdata = 32'(btn_level);
      OFF_EDGE_STATUS: rdata = 32'(edge_status);
      OFF_IRQ_MASK:    rdata = 32'(irq_mask);
      OFF_CTRL:        rdata = 32'(ctrl);
      default:         rdata = RESERVED_READ;
    endcase
  end

  // Next register values: toggle edges first, then byte-lane writes override LED_OUT; edge set beats W1C clear.
  always_comb begin
    led_out_next = led_out;
    if (ctrl[CTRL_TOGGLE_BIT] && !ctrl[CTRL_MIRROR_BIT]) begin
      led_out_next[NUM_BUTTONS-1:0] = led_out[NUM_BUTTONS-1:0] ^ btn_rise;
    end
    led_merge = (32'(led_out_next) & ~wmask) | wbits;
    if (wr && word_off == OFF_LED_OUT) begin
      led_out_next = led_merge[NUM_LEDS-1:0];
    end

    edge_clear = (wr && word_off == OFF_EDGE_STATUS) ? wbits : 32'h0;
    edge_next  = (edge_status & ~edge_clear[NUM_BUTTONS-1:0]) | btn_rise;

    irq_mask_next = irq_mask;
    mask_merge    = (32'(irq_mask) & ~wmask) | wbits;
    if (wr && word_off == OFF_IRQ_MASK) begin
      irq_mask_next = mask_merge[NUM_BUTTONS-1:0];
    end

    ctrl_next  = ctrl;
    ctrl_merge = (32'(ctrl) & ~wmask) | wbits;
    if (wr && word_off == OFF_CTRL) begin
      ctrl_next = ctrl_merge[1:0];
    end
  end

  // Bus handshake, register state and the registered interrupt level.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      wbs_ack_o   <= 1'b0;
      wbs_dat_o   <= '0;
      served      <= 1'b0;
      led_out     <= '0;
      edge_status <= '0;
      irq_mask    <= '0;
      ctrl        <= '0;
      irq         <= 1'b0;
    end else begin
      wbs_ack_o   <= take;
      wbs_dat_o   <= take ? rdata : 32'h0;
      served      <= sel_hit;
      led_out     <= led_out_next;
      edge_status <= edge_next;
      irq_mask    <= irq_mask_next;
      ctrl        <= ctrl_next;
      irq         <= |(edge_status & irq_mask);
    end
  end

  // LED drive: mirror shows debounced buttons on the low bits, otherwise the LED_OUT register.
  always_comb begin
    leds = led_out;
    if (ctrl[CTRL_MIRROR_BIT]) begin
      leds[NUM_BUTTONS-1:0] = btn_level;
    end
  end

endmodule

// File: tb/tb_wb_button_led_ctrl.sv
// Directed bench for wb_button_led_ctrl with a read-data scoreboard.
module tb_wb_button_led_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_n;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [2:0]  buttons;
  logic [7:0]  leds;
  logic [7:0]  leds_oeb;
  logic        irq;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  wb_button_led_ctrl #(
    .NUM_BUTTONS    (3),
    .NUM_LEDS       (8),
    .DEBOUNCE_CYCLES(4),
    .BASE_ADDR      (BASE)
  ) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_n (wb_rst_n),
    .wbs_stb_i(wbs_stb_i),
    .wbs_cyc_i(wbs_cyc_i),
    .wbs_we_i (wbs_we_i),
    .wbs_sel_i(wbs_sel_i),
    .wbs_adr_i(wbs_adr_i),
    .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o),
    .wbs_dat_o(wbs_dat_o),
    .buttons  (buttons),
    .leds     (leds),
    .leds_oeb (leds_oeb),
    .irq      (irq)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  task automatic apply_stimulus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                                input logic [3:0] sel, input string tag);
    bit          got;
    logic [31:0] exp_v;
    string       t;
    got       = 1'b0;
    wbs_stb_i = 1'b1;
    wbs_cyc_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = adr;
    wbs_dat_i = dat;
    wbs_sel_i = sel;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge wb_clk_i);
      #1;
      if (wbs_ack_o) begin
        got = 1'b1;
        if (!we) begin
          exp_v = exp_q.pop_front();
          t     = tag_q.pop_front();
          check_output(t, wbs_dat_o, exp_v);
        end
      end
    end
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    wbs_we_i  = 1'b0;
    if (!got) begin
      check_output({tag, " ack_timeout"}, 32'(wbs_ack_o), 32'd1);
      if (!we) begin
        exp_v = exp_q.pop_front();
        t     = tag_q.pop_front();
      end
    end
    tick(1);
    check_output({tag, " ack_width"}, 32'(wbs_ack_o), 32'd0);
    check_output({tag, " dat_idle"}, wbs_dat_o, 32'd0);
  endtask

  task automatic bus_write(input logic [31:0] off, input logic [31:0] dat, input logic [3:0] sel, input string tag);
    apply_stimulus(1'b1, BASE + off, dat, sel, tag);
  endtask

  task automatic bus_read(input logic [31:0] off, input logic [31:0] expected, input string tag);
    exp_q.push_back(expected);
    tag_q.push_back(tag);
    apply_stimulus(1'b0, BASE + off, 32'h0, 4'hF, tag);
  endtask

  // Watchdog so a stuck run still ends with a visible failure.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence covering reset, bus handshake, debounce, edges, irq and LED modes.
  initial begin
    wb_rst_n  = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    wbs_we_i  = 1'b0;
    wbs_sel_i = 4'h0;
    wbs_adr_i = 32'h0;
    wbs_dat_i = 32'h0;
    buttons   = 3'b000;
    tick(3);
    check_output("reset_ack", 32'(wbs_ack_o), 32'd0);
    check_output("reset_dat", wbs_dat_o, 32'd0);
    check_output("reset_leds", 32'(leds), 32'd0);
    check_output("reset_irq", 32'(irq), 32'd0);
    check_output("leds_oeb", 32'(leds_oeb), 32'd0);
    wb_rst_n = 1'b1;
    tick(1);

    for (int i = 0; i < 8; i++) begin
      bus_read(32'(i * 4), 32'h0, $sformatf("reset_read_%0d", i));
    end

    wbs_stb_i = 1'b1;
    wbs_cyc_i = 1'b1;
    wbs_adr_i = BASE;
    tick(1);
    check_output("held_sel_ack", 32'(wbs_ack_o), 32'd1);
    tick(1);
    check_output("held_sel_drop", 32'(wbs_ack_o), 32'd0);
    tick(1);
    check_output("held_sel_no_reack", 32'(wbs_ack_o), 32'd0);
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    tick(1);

    bus_write(32'h00, 32'hA5, 4'b0001, "led_write");
    check_output("leds_a5", 32'(leds), 32'hA5);
    bus_write(32'h00, 32'hFF, 4'b0000, "led_write_nosel");
    check_output("leds_nosel", 32'(leds), 32'hA5);
    bus_read(32'h00, 32'hA5, "led_readback");

    bus_write(32'h0C, 32'h2, 4'b0001, "irq_mask");
    buttons = 3'b111;
    tick(6);
    check_output("irq_before_edge", 32'(irq), 32'd0);
    tick(1);
    check_output("irq_after_edge", 32'(irq), 32'd1);
    bus_read(32'h04, 32'h7, "btn_in_pressed");
    bus_read(32'h08, 32'h7, "edge_all");
    bus_write(32'h08, 32'h2, 4'b0001, "w1c_bit1");
    check_output("irq_cleared", 32'(irq), 32'd0);
    bus_read(32'h08, 32'h5, "edge_after_w1c");

    buttons = 3'b000;
    tick(10);
    bus_write(32'h08, 32'h7, 4'b0001, "w1c_all");
    bus_read(32'h08, 32'h0, "edge_cleared");
    buttons = 3'b001;
    tick(3);
    buttons = 3'b000;
    tick(10);
    bus_read(32'h04, 32'h0, "glitch_btn");
    bus_read(32'h08, 32'h0, "glitch_edge");

    bus_write(32'h00, 32'h00, 4'b0001, "led_zero");
    bus_write(32'h10, 32'h2, 4'b0001, "ctrl_toggle");
    buttons = 3'b010;
    tick(8);
    check_output("toggle_first", 32'(leds), 32'h02);
    buttons = 3'b000;
    tick(8);
    check_output("toggle_release", 32'(leds), 32'h02);
    buttons = 3'b010;
    tick(8);
    check_output("toggle_second", 32'(leds), 32'h00);
    buttons = 3'b000;
    tick(8);

    bus_write(32'h10, 32'h1, 4'b0001, "ctrl_mirror");
    bus_write(32'h00, 32'hF0, 4'b0001, "led_f0");
    buttons = 3'b101;
    tick(8);
    check_output("mirror_leds", 32'(leds), 32'hF5);
    bus_read(32'h00, 32'hF0, "led_out_not_leds");

    buttons = 3'b000;
    tick(8);
    bus_write(32'h08, 32'h7, 4'b0001, "w1c_clear");
    bus_read(32'h08, 32'h0, "edge_clear2");
    buttons = 3'b100;
    tick(5);
    bus_write(32'h08, 32'h4, 4'b0001, "w1c_coincide");
    bus_read(32'h08, 32'h4, "set_wins");

    buttons = 3'b000;
    tick(8);
    wbs_stb_i = 1'b1;
    wbs_cyc_i = 1'b1;
    wbs_we_i  = 1'b1;
    wbs_adr_i = BASE;
    wbs_dat_i = 32'h3C;
    wbs_sel_i = 4'b0001;
    wb_rst_n  = 1'b0;
    tick(1);
    check_output("rst_no_ack", 32'(wbs_ack_o), 32'd0);
    check_output("rst_dat", wbs_dat_o, 32'd0);
    check_output("rst_leds", 32'(leds), 32'd0);
    check_output("rst_irq", 32'(irq), 32'd0);
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    wbs_we_i  = 1'b0;
    tick(1);
    wb_rst_n = 1'b1;
    tick(1);
    bus_read(32'h00, 32'h0, "rst_led_out");
    bus_read(32'h08, 32'h0, "rst_edge");
    bus_read(32'h0C, 32'h0, "rst_mask");
    bus_read(32'h10, 32'h0, "rst_ctrl");

    check_output("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_button_led_ctrl.md
# wb_button_led_ctrl

Parametrised Wishbone-slave peripheral for the user project area: synchronises and debounces `NUM_BUTTONS` button inputs, drives `NUM_LEDS` LED outputs, and reports sticky rising-edge events with a maskable interrupt. Successor to the fixed 3-button/8-LED peripheral. Adds:
- debounce;
- edge status with interrupt;
- hardware mirror and toggle LED modes.

Sits on the Caravel management Wishbone bus, with buttons/LEDs routed to `mprj_io`.

## Interface
Parameters:
- `NUM_BUTTONS`, 3: button count, 1..32.
- `NUM_LEDS`, 8: LED count, `NUM_BUTTONS`..32. Elaboration error if smaller than `NUM_BUTTONS`.
- `DEBOUNCE_CYCLES`, 1000: stable cycles required before accepting a new level, ≥2.
- `BASE_ADDR`, 32'h3000_0000: block base, 32-byte aligned.

Ports:
- `wb_clk_i` in 1: sole clock.
- `wb_rst_n` in 1: reset, synchronous, active-low.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` in 1: Wishbone classic controls.
- `wbs_sel_i` in 4: byte enables.
- `wbs_adr_i` in 32: byte address.
- `wbs_dat_i` in 32: write data.
- `wbs_ack_o` out 1: transfer acknowledge.
- `wbs_dat_o` out 32: read data.
- `buttons` in `NUM_BUTTONS`: raw asynchronous pins.
- `leds` out `NUM_LEDS`: LED drive.
- `leds_oeb` out `NUM_LEDS`: constant 0 (output enable).
- `irq` out 1: level interrupt.

## Operation
- Select: `stb & cyc & (adr[31:5] == BASE_ADDR[31:5])`. Word offset is `adr[4:2]`.
- Register map. Bits above the stated width read 0.
  - 0x00 `LED_OUT`: RW, `NUM_LEDS` bits.
  - 0x04 `BTN_IN`: RO, debounced levels.
  - 0x08 `EDGE_STATUS`: W1C, sticky rising edges.
  - 0x0C `IRQ_MASK`: RW, `NUM_BUTTONS` bits.
  - 0x10 `CTRL`: RW. Bit 0 `MIRROR`, bit 1 `TOGGLE`.
  - 0x14–0x1C: reserved, read 0, writes ignored, still acked.
- Writes honour `wbs_sel_i` per byte lane, including W1C.
- Debounce, per button:
  - 2-FF synchroniser feeding a counter.
  - Counter clears whenever the synced level equals the debounced level.
  - Otherwise it increments. When it reaches `DEBOUNCE_CYCLES-1`, the debounced bit takes the synced level and the counter clears.
  - Counter width is `$clog2(DEBOUNCE_CYCLES)`. The counter never wraps.
- Edge detect: a debounced 0→1 sets `EDGE_STATUS[i]`. It stays set until a 1 is written to that bit. If set and clear occur in the same cycle, set wins.
- `irq = |(EDGE_STATUS & IRQ_MASK)`, driven from registers only.
- LED modes:
  - `MIRROR=1`: `leds[NUM_BUTTONS-1:0]` = `BTN_IN`, upper bits = `LED_OUT`. `MIRROR` overrides `TOGGLE`.
  - `TOGGLE=1` (with `MIRROR=0`): each debounced rising edge on button i inverts `LED_OUT[i]`. A same-cycle bus write to `LED_OUT` wins for the written byte lanes.
  - Neither set: `leds = LED_OUT`.
- `LED_OUT` reads return the register value, not `leds`.

## Timing
- Reset: all of the following clear to 0 on the first rising edge with `wb_rst_n=0`:
  - `wbs_ack_o`, `wbs_dat_o`, `leds`, `irq`;
  - all registers, synchronisers, debounced bits and counters.
- Bus handshake:
  - `wbs_ack_o` rises one cycle after a select and is high for exactly one cycle.
  - A select held through ack is not re-acked. The next transfer needs a fresh select.
  - `wbs_dat_o` is valid with ack and is 0 otherwise.
  - Write side effects are visible on the cycle after ack.
- Reset asserted mid-transfer: ack is suppressed and the write is discarded.
- Latency from a pin edge to a `BTN_IN` change is 2 + `DEBOUNCE_CYCLES` cycles, provided the pin is stable throughout.
- `EDGE_STATUS` and the `TOGGLE` effect occur on the same edge as the `BTN_IN` change.
- `irq` follows one cycle later.
- A glitch shorter than `DEBOUNCE_CYCLES` synced cycles produces no change.

## Structure
- Package `wb_button_led_pkg`: register offset constants, `CTRL` bit indices, reserved-read value.
- Sub-module `button_debounce`: synchroniser, counter and edge pulse for one bit. Instantiated `NUM_BUTTONS` times via generate.
- Top level: bus decode, registers, LED mux.

## Test plan
Bench uses `DEBOUNCE_CYCLES=4`, `NUM_BUTTONS=3`, `NUM_LEDS=8`.
- Reset, then read all offsets → all 0. `leds`=0, `irq`=0, and each ack lasts exactly 1 cycle.
- Write 0xA5 to `LED_OUT` with `sel`=4'b0001 → `leds`=8'hA5. A second write of 0xFF with `sel`=4'b0000 leaves 8'hA5.
- Raise `buttons` to 3'b111 → `BTN_IN`=3'b111 exactly 6 cycles later, `EDGE_STATUS`=3'b111. With `IRQ_MASK`=3'b010, `irq`=1. Write 3'b010 to `EDGE_STATUS` → `irq`=0, status reads 3'b101.
- Pulse `buttons[0]` high for 3 cycles → `BTN_IN` and `EDGE_STATUS` stay 0.
- Set `CTRL.TOGGLE` with `LED_OUT`=0, press button 1 twice with debounced presses → `leds` goes 8'h02, then 8'h00. Then set `CTRL.MIRROR`, `LED_OUT`=8'hF0, buttons=3'b101 → `leds`=8'hF5.
- Hold button 2 so its debounced edge coincides with a W1C write of bit 2 → bit 2 remains set. Assert `wb_rst_n`=0 during a select → no ack, and register state is cleared.
